// File: rtl/lorenz_dac_spi.sv
// Lorenz integrator output stage: converts two selected 7.20 states to 12-bit
// offset-binary codes and ships them to a dual-channel SPI DAC, then pulses LDAC_n.
module lorenz_dac_spi #(
  parameter logic [1:0]         CHAN_A_SEL = 2'd0,
  parameter logic [1:0]         CHAN_B_SEL = 2'd2,
  parameter logic signed [27:0] OFFSET_A   = 28'sd0,
  parameter logic signed [27:0] OFFSET_B   = 28'sd26214400,
  parameter int                 SHIFT      = 14,
  parameter int                 CLK_DIV    = 2,
  parameter int                 CS_GAP     = 2,
  parameter int                 LDAC_W     = 2
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               sample_valid,
  input  logic signed [26:0] X_K,
  input  logic signed [26:0] Y_K,
  input  logic signed [26:0] Z_K,
  output logic               CS_n,
  output logic               SCK,
  output logic               MOSI,
  output logic               LDAC_n,
  output logic               busy,
  output logic [7:0]         overrun_cnt
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_SHIFT_A = 3'd2;
  localparam logic [2:0] ST_GAP_A   = 3'd3;
  localparam logic [2:0] ST_SHIFT_B = 3'd4;
  localparam logic [2:0] ST_GAP_B   = 3'd5;
  localparam logic [2:0] ST_LATCH   = 3'd6;

  localparam logic [15:0] PH_LAST   = 16'(2 * CLK_DIV - 1);
  localparam logic [15:0] PH_HIGH   = 16'(CLK_DIV);
  localparam logic [15:0] GAP_LAST  = 16'(CS_GAP - 1);
  localparam logic [15:0] LDAC_LAST = 16'(LDAC_W - 1);

  logic [2:0]  state_r, state_s;
  logic [15:0] cnt_r, cnt_s;
  logic [3:0]  bit_r, bit_s;
  logic [15:0] word_a_r, word_b_r;
  logic        cs_n_s, sck_s, mosi_s, ldac_n_s, busy_s;

  function automatic logic signed [26:0] pick_state(input logic [1:0] sel,
                                                     input logic signed [26:0] x,
                                                     input logic signed [26:0] y,
                                                     input logic signed [26:0] z);
    logic signed [26:0] v;
    case (sel)
      2'd0:    v = x;
      2'd1:    v = y;
      default: v = z;
    endcase
    return v;
  endfunction

  // Offset, floor-shift and clamp to [-2048, 2047]; +2048 is just an MSB flip.
  function automatic logic [11:0] dac_code(input logic signed [26:0] v,
                                           input logic signed [27:0] off);
    logic signed [27:0] d;
    logic signed [27:0] s;
    logic [11:0]        code;
    d = $signed({v[26], v}) - off;
    s = d >>> SHIFT;
    if (s > 28'sd2047) begin
      code = 12'hFFF;
    end else if (s < -28'sd2048) begin
      code = 12'h000;
    end else begin
      code = {~s[11], s[10:0]};
    end
    return code;
  endfunction

  // Frame sequencer: next state, bit index and per-state cycle counter.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    bit_s   = bit_r;
    case (state_r)
      ST_IDLE: begin
        if (sample_valid) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_s = ST_SHIFT_A;
        cnt_s   = 16'd0;
        bit_s   = 4'd0;
      end
      ST_SHIFT_A, ST_SHIFT_B: begin
        if (cnt_r == PH_LAST) begin
          cnt_s = 16'd0;
          if (bit_r == 4'd15) begin
            state_s = (state_r == ST_SHIFT_A) ? ST_GAP_A : ST_GAP_B;
            bit_s   = 4'd0;
          end else begin
            bit_s = bit_r + 4'd1;
          end
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      ST_GAP_A: begin
        if (cnt_r == GAP_LAST) begin
          state_s = ST_SHIFT_B;
          cnt_s   = 16'd0;
          bit_s   = 4'd0;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      ST_GAP_B: begin
        if (cnt_r == GAP_LAST) begin
          state_s = ST_LATCH;
          cnt_s   = 16'd0;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      ST_LATCH: begin
        if (cnt_r == LDAC_LAST) begin
          state_s = ST_IDLE;
          cnt_s   = 16'd0;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 16'd0;
        bit_s   = 4'd0;
      end
    endcase
  end

  // Output values decoded from the next state so the pins are registered but cycle-aligned.
  always_comb begin
    cs_n_s   = 1'b1;
    sck_s    = 1'b0;
    mosi_s   = 1'b0;
    ldac_n_s = (state_s != ST_LATCH);
    busy_s   = (state_s != ST_IDLE);
    if (state_s == ST_SHIFT_A) begin
      cs_n_s = 1'b0;
      sck_s  = (cnt_s >= PH_HIGH);
      mosi_s = word_a_r[4'd15 - bit_s];
    end else if (state_s == ST_SHIFT_B) begin
      cs_n_s = 1'b0;
      sck_s  = (cnt_s >= PH_HIGH);
      mosi_s = word_b_r[4'd15 - bit_s];
    end else begin
      cs_n_s = 1'b1;
    end
  end

  // State, captured words, output pins and overrun counter.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 16'd0;
      bit_r       <= 4'd0;
      word_a_r    <= 16'd0;
      word_b_r    <= 16'd0;
      CS_n        <= 1'b1;
      SCK         <= 1'b0;
      MOSI        <= 1'b0;
      LDAC_n      <= 1'b1;
      busy        <= 1'b0;
      overrun_cnt <= 8'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      bit_r   <= bit_s;
      CS_n    <= cs_n_s;
      SCK     <= sck_s;
      MOSI    <= mosi_s;
      LDAC_n  <= ldac_n_s;
      busy    <= busy_s;
      if (state_r == ST_IDLE && sample_valid) begin
        word_a_r <= {4'h7, dac_code(pick_state(CHAN_A_SEL, X_K, Y_K, Z_K), OFFSET_A)};
        word_b_r <= {4'hF, dac_code(pick_state(CHAN_B_SEL, X_K, Y_K, Z_K), OFFSET_B)};
      end
      if (sample_valid && state_r != ST_IDLE && overrun_cnt != 8'hFF) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_lorenz_dac_spi.sv
// Bench for lorenz_dac_spi: a default instance and a fast instance (CLK_DIV=CS_GAP=LDAC_W=1,
// channel A = Y) are checked every cycle against a timeline model of the frame.
module tb_lorenz_dac_spi;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]         rst_n, sv;
  logic signed [26:0] x_k, y_k, z_k;
  logic [1:0]         cs_n, sck, mosi, ldac_n, busy;
  logic [7:0]         ovr [2];

  lorenz_dac_spi u_dflt (
    .CLOCK_50(clk), .reset(rst_n[0]), .sample_valid(sv[0]),
    .X_K(x_k), .Y_K(y_k), .Z_K(z_k),
    .CS_n(cs_n[0]), .SCK(sck[0]), .MOSI(mosi[0]), .LDAC_n(ldac_n[0]),
    .busy(busy[0]), .overrun_cnt(ovr[0]));

  lorenz_dac_spi #(.CHAN_A_SEL(2'd1), .CLK_DIV(1), .CS_GAP(1), .LDAC_W(1)) u_fast (
    .CLOCK_50(clk), .reset(rst_n[1]), .sample_valid(sv[1]),
    .X_K(x_k), .Y_K(y_k), .Z_K(z_k),
    .CS_n(cs_n[1]), .SCK(sck[1]), .MOSI(mosi[1]), .LDAC_n(ldac_n[1]),
    .busy(busy[1]), .overrun_cnt(ovr[1]));

  localparam longint OFF_B = 64'sd26214400;
  int md [2] = '{2, 1};
  int mg [2] = '{2, 1};
  int ml [2] = '{2, 1};
  int ms [2] = '{0, 1};

  int checks = 0;
  int errors = 0;

  longint      cyc = 0;
  bit          m_act [2];
  longint      m_n0 [2];
  logic [15:0] m_wa [2], m_wb [2];
  int          m_ovr [2];
  bit          chk_en [2];
  bit          rst_edge [2];
  logic        prev_cs [2], prev_sck [2], prev_mosi [2];
  logic [15:0] cap_sh [2], last_a [2], last_b [2];
  int          cap_n [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Spec conversion in plain integer arithmetic: floor divide by 2^14, clamp, offset.
  function automatic int conv(input longint v, input longint off);
    longint d, q;
    d = v - off;
    q = d / 16384;
    if (d < 0 && q * 16384 != d) q = q - 1;
    if (q > 2047) q = 2047;
    if (q < -2048) q = -2048;
    return int'(q + 2048);
  endfunction

  function automatic longint pick(input int sel, input longint x, input longint y, input longint z);
    if (sel == 0) return x;
    else if (sel == 1) return y;
    else return z;
  endfunction

  function automatic longint frame_len(input int i);
    return 1 + 64 * md[i] + 2 * mg[i] + ml[i];
  endfunction

  // Expected {busy, CS_n, SCK, MOSI, LDAC_n} at 'rel' cycles after the accepting cycle.
  function automatic logic [4:0] exp_out(input longint rel, input int d, input int g, input int l,
                                         input logic [15:0] wa, input logic [15:0] wb);
    logic b, c, s, m, ld;
    longint a0, b0, l0, f, j;
    int bi;
    f  = 1 + 64 * d + 2 * g + l;
    a0 = 2;
    b0 = 2 + 32 * d + g;
    l0 = 2 + 64 * d + 2 * g;
    b = (rel >= 1 && rel <= f);
    c = 1'b1; s = 1'b0; m = 1'b0; ld = 1'b1;
    if (rel >= a0 && rel < a0 + 32 * d) begin
      j = rel - a0; c = 1'b0; s = ((j % (2 * d)) >= d);
      bi = 15 - int'(j / (2 * d)); m = wa[bi[3:0]];
    end else if (rel >= b0 && rel < b0 + 32 * d) begin
      j = rel - b0; c = 1'b0; s = ((j % (2 * d)) >= d);
      bi = 15 - int'(j / (2 * d)); m = wb[bi[3:0]];
    end else if (rel >= l0 && rel < l0 + l) begin
      ld = 1'b0;
    end
    return {b, c, s, m, ld};
  endfunction

  // Model update on each rising edge, then per-cycle comparison and SPI word capture.
  always @(posedge clk) begin
    logic [4:0] e;
    for (int i = 0; i < 2; i++) begin
      rst_edge[i] = (rst_n[i] !== 1'b1);
      if (rst_n[i] !== 1'b1) begin
        m_act[i] = 1'b0; m_ovr[i] = 0; chk_en[i] = 1'b1;
      end else if (sv[i]) begin
        if (m_act[i] && cyc > m_n0[i] && cyc <= m_n0[i] + frame_len(i)) begin
          if (m_ovr[i] < 255) m_ovr[i]++;
        end else begin
          m_act[i] = 1'b1; m_n0[i] = cyc;
          m_wa[i] = 16'h7000 | 16'(conv(pick(ms[i], longint'(x_k), longint'(y_k), longint'(z_k)), 0));
          m_wb[i] = 16'hF000 | 16'(conv(longint'(z_k), OFF_B));
        end
      end
    end
    cyc++;
    #1;
    for (int i = 0; i < 2; i++) begin
      if (chk_en[i]) begin
        e = m_act[i] ? exp_out(cyc - m_n0[i], md[i], mg[i], ml[i], m_wa[i], m_wb[i]) : 5'b01001;
        chk($sformatf("u%0d busy", i), 32'(busy[i]), 32'(e[4]));
        chk($sformatf("u%0d cs_n", i), 32'(cs_n[i]), 32'(e[3]));
        chk($sformatf("u%0d sck", i), 32'(sck[i]), 32'(e[2]));
        chk($sformatf("u%0d mosi", i), 32'(mosi[i]), 32'(e[1]));
        chk($sformatf("u%0d ldac_n", i), 32'(ldac_n[i]), 32'(e[0]));
        chk($sformatf("u%0d overrun", i), 32'(ovr[i]), 32'(m_ovr[i]));
        if (rst_edge[i]) begin
          cap_n[i] = 0;
        end else begin
          if (prev_cs[i] === 1'b1 && cs_n[i] === 1'b0) cap_n[i] = 0;
          if (cs_n[i] === 1'b0 && prev_sck[i] === 1'b0 && sck[i] === 1'b1) begin
            chk($sformatf("u%0d mosi stable at sck rise", i), 32'(mosi[i]), 32'(prev_mosi[i]));
            cap_sh[i] = {cap_sh[i][14:0], mosi[i]};
            cap_n[i]++;
          end
          if (prev_cs[i] === 1'b0 && cs_n[i] === 1'b1) begin
            chk($sformatf("u%0d sck rises per window", i), 32'(cap_n[i]), 32'd16);
            if (cap_sh[i][15]) last_b[i] = cap_sh[i];
            else last_a[i] = cap_sh[i];
          end
        end
        prev_cs[i] = cs_n[i]; prev_sck[i] = sck[i]; prev_mosi[i] = mosi[i];
      end
    end
  end

  task automatic do_reset();
    rst_n = 2'b00; sv = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 2'b11;
  endtask

  task automatic pulse_and_wait(input int len);
    sv = 2'b11;
    @(negedge clk);
    sv = 2'b00;
    repeat (len - 1) @(negedge clk);
  endtask

  function automatic logic signed [26:0] rnd_val(input longint centre);
    if ($urandom_range(0, 3) == 0) return 27'($urandom);
    return 27'(centre + longint'($urandom_range(0, 8388608)) - 64'sd4194304);
  endfunction

  task automatic chk_words(input string tag, input logic [15:0] a0, input logic [15:0] b0,
                           input logic [15:0] a1, input logic [15:0] b1);
    chk({tag, " u0 word A"}, 32'(last_a[0]), 32'(a0));
    chk({tag, " u0 word B"}, 32'(last_b[0]), 32'(b0));
    chk({tag, " u1 word A"}, 32'(last_a[1]), 32'(a1));
    chk({tag, " u1 word B"}, 32'(last_b[1]), 32'(b1));
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      prev_cs[i] = 1'b1; prev_sck[i] = 1'b0; prev_mosi[i] = 1'b0; cap_n[i] = 0;
      cap_sh[i] = 16'd0; last_a[i] = 16'd0; last_b[i] = 16'd0; m_ovr[i] = 0;
    end
    rst_n = 2'b00; sv = 2'b00; x_k = '0; y_k = '0; z_k = '0;
    repeat (3) @(negedge clk);
    rst_n = 2'b11;
    @(negedge clk);
    chk("reset cs_n", 32'(cs_n), 32'd3);
    chk("reset sck", 32'(sck), 32'd0);
    chk("reset ldac_n", 32'(ldac_n), 32'd3);
    chk("reset busy", 32'(busy), 32'd0);

    chk("pin x=-1.0", 32'(conv(-64'sd1048576, 0)), 32'd1984);
    chk("pin z=25.0", 32'(conv(64'sd26214400, OFF_B)), 32'd2048);
    chk("pin x=+63.0", 32'(conv(64'sd66060288, 0)), 32'd4095);
    chk("pin x=-64.0", 32'(conv(-64'sd67108864, 0)), 32'd0);
    chk("pin z=60.0", 32'(conv(64'sd62914560, OFF_B)), 32'd4095);
    chk("pin y=0.1", 32'(conv(64'sd104858, 0)), 32'd2054);
    chk("pin z=0", 32'(conv(64'sd0, OFF_B)), 32'd448);

    // Nominal frame with literal timing points on the default instance.
    x_k = -27'sd1048576; y_k = 27'sd104858; z_k = 27'sd26214400;
    for (int t = 0; t <= 140; t++) begin
      if (t == 1) chk("nominal busy at N+1", 32'(busy[0]), 32'd1);
      if (t == 2) chk("nominal cs_n at N+2", 32'(cs_n[0]), 32'd0);
      if (t == 134 || t == 135) chk("nominal ldac_n low", 32'(ldac_n[0]), 32'd0);
      if (t == 136) chk("nominal busy at N+136", 32'(busy[0]), 32'd0);
      sv = (t == 0) ? 2'b11 : 2'b00;
      @(negedge clk);
    end
    chk_words("nominal", 16'h77C0, 16'hF800, 16'h7806, 16'hF800);

    x_k = 27'sd66060288; y_k = 27'sd66060288; z_k = 27'sd62914560;
    pulse_and_wait(140);
    chk_words("sat high", 16'h7FFF, 16'hFFFF, 16'h7FFF, 16'hFFFF);
    x_k = -27'sd67108864; y_k = -27'sd67108864; z_k = 27'sd0;
    pulse_and_wait(140);
    chk_words("sat low", 16'h7000, 16'hF1C0, 16'h7000, 16'hF1C0);

    // Overrun: N+40 and N+135 dropped, N+136 accepted on the default instance.
    do_reset();
    for (int t = 0; t <= 280; t++) begin
      if (t == 137) chk("accept at N+F+1", 32'(busy[0]), 32'd1);
      sv = (t == 0 || t == 40 || t == 135 || t == 136) ? 2'b11 : 2'b00;
      @(negedge clk);
    end
    chk("overrun u0 count", 32'(ovr[0]), 32'd2);
    chk("overrun u1 count", 32'(ovr[1]), 32'd2);

    sv = 2'b11;
    repeat (300) @(negedge clk);
    sv = 2'b00;
    repeat (140) @(negedge clk);
    chk("overrun u0 saturate", 32'(ovr[0]), 32'd255);
    chk("overrun u1 saturate", 32'(ovr[1]), 32'd255);

    // Reset mid-frame, then a clean frame.
    x_k = 27'sd5242880; y_k = 27'sd5242880; z_k = 27'sd5242880;
    for (int t = 0; t <= 41; t++) begin
      if (t == 41) begin
        chk("midreset cs_n", 32'(cs_n[0]), 32'd1);
        chk("midreset sck", 32'(sck[0]), 32'd0);
        chk("midreset mosi", 32'(mosi[0]), 32'd0);
        chk("midreset ldac_n", 32'(ldac_n[0]), 32'd1);
        chk("midreset busy", 32'(busy[0]), 32'd0);
        chk("midreset overrun", 32'(ovr[0]), 32'd0);
      end
      sv = (t == 0) ? 2'b11 : 2'b00;
      rst_n = (t == 40) ? 2'b00 : 2'b11;
      @(negedge clk);
    end
    x_k = 27'sd0; y_k = -27'sd524288; z_k = 27'sd31457280;
    pulse_and_wait(140);
    chk_words("after reset", 16'h7800, 16'hF940, 16'h77E0, 16'hF940);

    // Randomized traffic with occasional resets.
    for (int t = 0; t < 4000; t++) begin
      x_k = rnd_val(0); y_k = rnd_val(0); z_k = rnd_val(26214400);
      sv[0] = ($urandom_range(0, 99) < 3);
      sv[1] = ($urandom_range(0, 99) < 3);
      rst_n = ($urandom_range(0, 599) == 0) ? 2'b00 : 2'b11;
      @(negedge clk);
    end
    sv = 2'b00; rst_n = 2'b11;
    repeat (150) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
